// File: rtl/fifo_w2n.sv
// rtl/fifo_w2n.sv - 32-bit write / 4-bit read asymmetric FIFO with partial-word writes
module fifo_w2n #(
    parameter int DEPTH = 32,
    parameter int WR_W  = 32,
    parameter int RD_W  = 4,
    parameter int NPW   = WR_W / RD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [WR_W-1:0]            wr_data,
    input  logic [3:0]                 wr_cnt,
    output logic                       wr_rdy,
    input  logic                       rd,
    output logic [RD_W-1:0]            rd_data,
    output logic                       rd_vld,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    input  logic                       clr,
    output logic                       err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [RD_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            err_q, err_d;

    logic            cnt_ok;
    logic            wr_acc;
    logic            rd_acc;
    logic            wr_bad;
    logic            rd_bad;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == PW'(DEPTH));
    assign wr_rdy  = (count <= PW'(DEPTH - NPW));
    assign rd_vld  = !empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign err     = err_q;

    // Flags come from the pre-edge count, so a same-cycle pop never frees room for a push.
    assign cnt_ok = (wr_cnt != 4'd0) && (wr_cnt <= 4'(NPW));
    assign wr_acc = wr && wr_rdy && cnt_ok && !clr;
    assign rd_acc = rd && !empty && !clr;
    assign wr_bad = wr && (!wr_rdy || !cnt_ok) && !clr;
    assign rd_bad = rd && empty && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (clr) begin
            rd_ptr_d = wr_ptr_q;
            err_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(wr_cnt);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (wr_bad || rd_bad) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Only the valid low nibbles are stored; the index wraps naturally across the storage end.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < NPW; k++) begin
                if (4'(k) < wr_cnt) begin
                    mem_q[wr_ptr_q[AW-1:0] + AW'(k)] <= wr_data[k*RD_W +: RD_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_w2n.sv
// tb/tb_fifo_w2n.sv - directed scoreboard bench for fifo_w2n
module tb_fifo_w2n;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [31:0] wr_data;
    logic [3:0]  wr_cnt;
    logic        wr_rdy;
    logic        rd;
    logic [3:0]  rd_data;
    logic        rd_vld;
    logic [5:0]  count;
    logic        full;
    logic        empty;
    logic        clr;
    logic        err;

    int checks   = 0;
    int failures = 0;
    logic [3:0] q[$];
    logic       errm = 1'b0;

    fifo_w2n dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .wr_data (wr_data),
        .wr_cnt  (wr_cnt),
        .wr_rdy  (wr_rdy),
        .rd      (rd),
        .rd_data (rd_data),
        .rd_vld  (rd_vld),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .clr     (clr),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int n = q.size();
        chk({tag, ".count"}, count, n);
        chk({tag, ".empty"}, empty, n == 0);
        chk({tag, ".full"}, full, n == 32);
        chk({tag, ".wr_rdy"}, wr_rdy, n <= 24);
        chk({tag, ".rd_vld"}, rd_vld, n != 0);
        chk({tag, ".err"}, err, errm);
    endtask

    // One clock of stimulus; the queue models what the FIFO should hold afterwards.
    task automatic step(input logic w, input logic [31:0] d, input logic [3:0] c,
                        input logic r, input logic cl);
        int  n = q.size();
        bit  ok_w;
        wr = w; wr_data = d; wr_cnt = c; rd = r; clr = cl;
        #1;
        chk("rd_data", rd_data, (n > 0) ? q[0] : 4'h0);
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0; wr_cnt = 4'd0; wr_data = '0;
        if (cl) begin
            q.delete();
            errm = 1'b0;
        end else begin
            ok_w = (n <= 24) && (c >= 1) && (c <= 8);
            if (w && !ok_w) errm = 1'b1;
            if (r && n == 0) errm = 1'b1;
            if (r && n > 0) void'(q.pop_front());
            if (w && ok_w) begin
                for (int k = 0; k < c; k++) q.push_back(d[k*4 +: 4]);
            end
        end
        chk_flags("step");
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0] part_exp [4];
        part_exp[0] = 4'hC; part_exp[1] = 4'hB; part_exp[2] = 4'hA; part_exp[3] = 4'hD;
        rst = 1'b0; wr = 1'b0; wr_data = '0; wr_cnt = '0; rd = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.count", count, 0);
        chk("reset.empty", empty, 1);
        chk("reset.rd_vld", rd_vld, 0);
        chk("reset.wr_rdy", wr_rdy, 1);
        chk("reset.rd_data", rd_data, 0);
        chk("reset.err", err, 0);
        chk("reset.full", full, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);

        // full word then nibble readout
        step(1'b1, 32'h87654321, 4'd8, 1'b0, 1'b0);
        chk("word.count8", count, 8);
        for (int i = 0; i < 8; i++) begin
            chk("word.seq", rd_data, i + 1);
            chk("word.cnt", count, 8 - i);
            step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        end
        chk("word.empty", empty, 1);

        // partial words never expose padding
        step(1'b1, 32'hFFFFFABC, 4'd3, 1'b0, 1'b0);
        step(1'b1, 32'h0000000D, 4'd1, 1'b0, 1'b0);
        chk("part.count4", count, 4);
        for (int i = 0; i < 4; i++) begin
            chk("part.seq", rd_data, part_exp[i]);
            step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        end

        // wr_rdy boundary at 24/25
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 4'd8, 1'b0, 1'b0);
        chk("fill.count24", count, 24);
        chk("fill.rdy24", wr_rdy, 1);
        step(1'b1, $urandom, 4'd1, 1'b0, 1'b0);
        chk("fill.count25", count, 25);
        chk("fill.rdy25", wr_rdy, 0);
        step(1'b1, $urandom, 4'd1, 1'b0, 1'b0);
        chk("fill.drop", count, 25);
        chk("fill.err", err, 1);
        drain(1);
        step(1'b1, $urandom, 4'd7, 1'b0, 1'b0);
        chk("fill.count31", count, 31);
        drain(31);

        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b1);
        chk("clr.err0", err, 0);
        step(1'b1, 32'h12345678, 4'd0, 1'b0, 1'b0);
        chk("cnt0.err", err, 1);
        chk("cnt0.count", count, 0);
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b1);

        // completely full, then one pop
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 4'd8, 1'b0, 1'b0);
        chk("full.count", count, 32);
        chk("full.full", full, 1);
        step(1'b1, $urandom, 4'd8, 1'b0, 1'b0);
        drain(1);
        chk("full.count31", count, 31);
        chk("full.full0", full, 0);
        drain(31);
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b1);

        // walk pointers to index 28, then wrap with concurrent read/write
        for (int i = 0; i < 2; i++) step(1'b1, $urandom, 4'd8, 1'b0, 1'b0);
        drain(16);
        step(1'b1, 32'h76543210, 4'd8, 1'b1, 1'b0);
        chk("wrap.err", err, 1);
        chk("wrap.count8", count, 8);
        chk("wrap.head", rd_data, 0);
        step(1'b1, 32'hFEDCBA98, 4'd8, 1'b1, 1'b0);
        chk("wrap.plus7", count, 15);
        for (int i = 1; i < 9; i++) begin
            chk("wrap.seq", rd_data, i);
            step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        end
        chk("wrap.count7", count, 7);

        // clr at count 13 with err set; a same-cycle write is discarded
        step(1'b1, $urandom, 4'd6, 1'b0, 1'b0);
        chk("clr.count13", count, 13);
        chk("clr.err1", err, 1);
        step(1'b1, 32'hAAAAAAAA, 4'd8, 1'b1, 1'b1);
        chk("clr.count0", count, 0);
        chk("clr.empty", empty, 1);
        chk("clr.err", err, 0);
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        chk("clr.nowr", count, 0);

        // asynchronous reset between edges
        step(1'b1, 32'h55554321, 4'd8, 1'b0, 1'b0);
        step(1'b1, 32'h0, 4'd9, 1'b0, 1'b0);
        chk("arst.pre_err", err, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.count", count, 0);
        chk("arst.empty", empty, 1);
        chk("arst.rd_vld", rd_vld, 0);
        chk("arst.wr_rdy", wr_rdy, 1);
        chk("arst.rd_data", rd_data, 0);
        chk("arst.err", err, 0);
        q.delete();
        errm = 1'b0;
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 32'h00000321, 4'd3, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            chk("arst.seq", rd_data, i);
            step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
